mc_datapath: RTL
================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter WIDTH, default 32: datapath, register and memory word width; legal values 16..64.
REQ-002 Parameter NREGS, default 32: register-file entries; power of two, 2..32.
REQ-003 Parameter MEM_DEPTH, default 256: data-memory words; power of two, at least 2.
REQ-004 Port clk  in  1: single clock, rising edge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Port inst  in  32: MIPS-format instruction (rs[25:21], rt[20:16], rd[15:11], shamt[10:6], imm[15:0]).
REQ-007 Port inst_valid  in  1: inst and control inputs are valid this cycle.
REQ-008 Port inst_ready  out  1: block is able to accept an instruction.
REQ-009 Ports regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl  in  1 each: per-instruction controls, same meaning as the single-cycle datapath.
REQ-010 Port aluctrl  in  4: ALU operation.
REQ-011 Port done  out  1: one-cycle pulse at instruction retirement.
REQ-012 Ports zero, msb  out  1 each: ALU result is zero / ALU result MSB, held from EXEC.
REQ-013 Ports write, regout  out  WIDTH each: write-back value / ALU result of the last retired instruction.

Function
REQ-014 Handshake: acceptance occurs when inst_valid and inst_ready are both high on a clock edge; inst and all controls are latched at acceptance.
REQ-015 inst_ready is high only in state IDLE.
REQ-016 FSM states: IDLE -> DECODE -> EXEC -> MEM -> WB -> IDLE; one cycle per state except IDLE, which waits for acceptance.
REQ-017 DECODE: register A = reg[rt] if shiftctrl else reg[rs]; register B = reg[rt]; both latched.
REQ-018 Immediate: imm is sign-extended to WIDTH if extop else zero-extended; shamt is zero-extended.
REQ-019 Operand B = shamt if shiftctrl, else imm if alusrc, else register B.
REQ-020 aluctrl: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 1/0); other codes give result 0.
REQ-021 Shifts use B[log2(WIDTH)-1:0]; arithmetic wraps modulo 2^WIDTH.
REQ-022 EXEC latches the ALU result, zero and msb.
REQ-023 MEM: the memory index is ALU result[log2(MEM_DEPTH)-1:0]; upper bits are ignored (wrap-around); a write of register B occurs in this cycle if memwrite; read data is registered.
REQ-024 WB: write value = memory data if mem2reg else ALU result; reg[regdst ? rd : rt] is written if regwrite; done pulses; write and regout update.
REQ-025 A destination index at or above NREGS is truncated modulo NREGS; register 0 is hardwired to 0, and writes to it are discarded.
REQ-026 Register reads in DECODE observe all prior WB writes (no hazard: one instruction in flight).
REQ-027 inst_valid is ignored outside IDLE; an instruction is never dropped once accepted, except on reset.

Reset
REQ-028 rst forces IDLE immediately: inst_ready=1, done=0, zero=0, msb=0, write=0, regout=0.
REQ-029 rst clears all registers to 0; data-memory contents are not reset.
REQ-030 rst asserted mid-instruction aborts that instruction, including suppression of any pending register write.
REQ-031 An aborted instruction that has already passed MEM leaves its memory write in place.

Configuration
REQ-032 Macro MC_DATAPATH_SKIPMEM_EN defined: when memwrite=0 and mem2reg=0, EXEC goes directly to WB, giving an acceptance-to-done latency of 3 cycles; all other instructions take 4 cycles.
REQ-033 Macro MC_DATAPATH_SKIPMEM_EN undefined: every instruction passes through MEM, giving a fixed latency of 4 cycles.

Verification
REQ-034 Reset then idle: inst_ready=1; all outputs 0; a read of reg5 via regout=reg5 OR 0 returns 0.
REQ-035 ADDI with rs=0, rt=3, imm=0xFFFF, extop=1, alusrc=1, regwrite=1, aluctrl=0010 -> done after 4 cycles (3 with SKIPMEM); write=all-ones, msb=1, reg3=-1.
REQ-036 SW of reg3 to address 4, then LW from address 4+MEM_DEPTH into rt=7 -> reg7=-1 (address wrap); SW asserts no regwrite.
REQ-037 SLL with rt=7, shamt=4, shiftctrl=1, aluctrl=0100 -> result 0xF...F0; write to rd=0 leaves reg0=0.
REQ-038 inst_valid held high continuously -> exactly one acceptance per IDLE visit, with no duplicate or lost instruction.
REQ-039 rst asserted during EXEC of an ADD to reg9 -> reg9 remains 0, no done pulse, inst_ready=1 the next cycle.

Source files
------------

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-style datapath: IDLE -> DECODE -> EXEC -> MEM -> WB, one instruction in flight.
// Define MC_DATAPATH_SKIPMEM_EN to let non-memory instructions bypass the MEM state.
module mc_datapath #(
   parameter int WIDTH     = 32,
   parameter int NREGS     = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             inst_valid,
   output logic             inst_ready,
   input  logic             regwrite,
   input  logic             regdst,
   input  logic             extop,
   input  logic             alusrc,
   input  logic             memwrite,
   input  logic             mem2reg,
   input  logic             shiftctrl,
   input  logic [3:0]       aluctrl,
   output logic             done,
   output logic             zero,
   output logic             msb,
   output logic [WIDTH-1:0] write,
   output logic [WIDTH-1:0] regout
);
   localparam int RAW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   state_t state_reg, state_next;

   logic [31:0]      inst_reg;
   logic             regwrite_reg, regdst_reg, extop_reg, alusrc_reg;
   logic             memwrite_reg, mem2reg_reg, shiftctrl_reg;
   logic [3:0]       aluctrl_reg;
   logic [WIDTH-1:0] a_reg, b_reg, alu_reg, write_reg, regout_reg;
   logic             zero_reg, msb_reg, done_reg;

   logic [4:0]       rs, rt, rd, shamt;
   logic [15:0]      imm;
   logic [RAW-1:0]   rs_idx, rt_idx, rd_idx;

   assign rs     = inst_reg[25:21];
   assign rt     = inst_reg[20:16];
   assign rd     = inst_reg[15:11];
   assign shamt  = inst_reg[10:6];
   assign imm    = inst_reg[15:0];
   assign rs_idx = rs[RAW-1:0];
   assign rt_idx = rt[RAW-1:0];
   assign rd_idx = rd[RAW-1:0];

   // Opcode and index bits above the register-file size carry no meaning here.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst_reg[31:26], rs, rt, rd};

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      inst_ready = 1'b0;
      case (state_reg)
         S_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) state_next = S_DECODE;
         end
         S_DECODE: state_next = S_EXEC;
         S_EXEC: begin
`ifdef MC_DATAPATH_SKIPMEM_EN
            state_next = (memwrite_reg || mem2reg_reg) ? S_MEM : S_WB;
`else
            state_next = S_MEM;
`endif
         end
         S_MEM:   state_next = S_WB;
         S_WB:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- register file ----------------
   logic [WIDTH-1:0] rf [NREGS];
   logic             rf_we;
   logic [RAW-1:0]   rf_waddr;
   logic [WIDTH-1:0] wb_value;
   logic [WIDTH-1:0] mem_rdata_reg;

   assign wb_value = mem2reg_reg ? mem_rdata_reg : alu_reg;
   assign rf_we    = (state_reg == S_WB) && regwrite_reg;
   assign rf_waddr = regdst_reg ? rd_idx : rt_idx;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
         if (gi == 0) begin : g_zero
            assign rf[gi] = '0;
         end else begin : g_reg
            logic [WIDTH-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
               if (rst)                                   q_reg <= '0;
               else if (rf_we && rf_waddr == RAW'(gi))    q_reg <= wb_value;
            end
            assign rf[gi] = q_reg;
         end
      end
   endgenerate

   // ---------------- ALU ----------------
   logic [WIDTH-1:0] imm_ext, opb, alu_res;
   logic [SHW-1:0]   shift_amt;

   always_comb begin
      imm_ext = extop_reg ? WIDTH'($signed(imm)) : WIDTH'(imm);
      if (shiftctrl_reg)   opb = WIDTH'(shamt);
      else if (alusrc_reg) opb = imm_ext;
      else                 opb = b_reg;
      shift_amt = opb[SHW-1:0];
      case (aluctrl_reg)
         4'b0000: alu_res = a_reg & opb;
         4'b0001: alu_res = a_reg | opb;
         4'b0010: alu_res = a_reg + opb;
         4'b0011: alu_res = a_reg ^ opb;
         4'b0100: alu_res = a_reg << shift_amt;
         4'b0101: alu_res = a_reg >> shift_amt;
         4'b0110: alu_res = a_reg - opb;
         4'b0111: alu_res = WIDTH'($signed(a_reg) < $signed(opb));
         default: alu_res = '0;
      endcase
   end

   // ---------------- data memory (contents survive reset) ----------------
   logic [WIDTH-1:0] mem [MEM_DEPTH];
   logic [MAW-1:0]   mem_addr;
   assign mem_addr = alu_reg[MAW-1:0];

   always_ff @(posedge clk) begin
      if (state_reg == S_MEM) begin
         if (memwrite_reg) mem[mem_addr] <= b_reg;
         mem_rdata_reg <= mem[mem_addr];
      end
   end

   // ---------------- datapath and output registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_reg      <= '0;
         regwrite_reg  <= 1'b0;
         regdst_reg    <= 1'b0;
         extop_reg     <= 1'b0;
         alusrc_reg    <= 1'b0;
         memwrite_reg  <= 1'b0;
         mem2reg_reg   <= 1'b0;
         shiftctrl_reg <= 1'b0;
         aluctrl_reg   <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         alu_reg       <= '0;
         zero_reg      <= 1'b0;
         msb_reg       <= 1'b0;
         write_reg     <= '0;
         regout_reg    <= '0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= (state_reg == S_WB);
         case (state_reg)
            S_IDLE: if (inst_valid) begin
               inst_reg      <= inst;
               regwrite_reg  <= regwrite;
               regdst_reg    <= regdst;
               extop_reg     <= extop;
               alusrc_reg    <= alusrc;
               memwrite_reg  <= memwrite;
               mem2reg_reg   <= mem2reg;
               shiftctrl_reg <= shiftctrl;
               aluctrl_reg   <= aluctrl;
            end
            S_DECODE: begin
               // Shifts take their data operand from rt, as in the single-cycle datapath.
               a_reg <= rf[shiftctrl_reg ? rt_idx : rs_idx];
               b_reg <= rf[rt_idx];
            end
            S_EXEC: begin
               alu_reg  <= alu_res;
               zero_reg <= (alu_res == '0);
               msb_reg  <= alu_res[WIDTH-1];
            end
            S_WB: begin
               write_reg  <= wb_value;
               regout_reg <= alu_reg;
            end
            default: ;
         endcase
      end
   end

   assign done   = done_reg;
   assign zero   = zero_reg;
   assign msb    = msb_reg;
   assign write  = write_reg;
   assign regout = regout_reg;
endmodule
